// File: rtl/demux4_32_buf_if.sv
// rtl/demux4_32_buf_if.sv - routed input stream and four buffered output ports
interface demux4_32_buf_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data0;
    logic [WIDTH-1:0] out_data1;
    logic [WIDTH-1:0] out_data2;
    logic [WIDTH-1:0] out_data3;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic             busy;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data0, out_data1, out_data2, out_data3, out_valid, busy
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data0, out_data1, out_data2, out_data3, out_valid, busy
    );
endinterface

// File: rtl/demux4_32_buf.sv
// rtl/demux4_32_buf.sv - 1-to-4 demultiplexer with a 2-entry FIFO per output port
module demux4_32_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    demux4_32_buf_if.slave        bus
);
    localparam logic [1:0] FULL_CNT = 2'(DEPTH);

    logic [WIDTH-1:0] mem_q [4][2];
    logic [WIDTH-1:0] mem_d [4][2];
    logic [3:0]       wptr_q, wptr_d;
    logic [3:0]       rptr_q, rptr_d;
    logic [1:0]       cnt_q [4];
    logic [1:0]       cnt_d [4];
    logic             in_ready;

    // Fullness only; a pop in the same cycle never frees room for the push.
    assign in_ready = reset && (cnt_q[bus.in_sel] != FULL_CNT);

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        for (int k = 0; k < 4; k++) begin
            logic push_k;
            logic pop_k;
            push_k = bus.in_valid && in_ready && (bus.in_sel == 2'(k));
            pop_k  = (cnt_q[k] != 2'd0) && bus.out_ready[k];
            if (push_k) begin
                mem_d[k][wptr_q[k]] = bus.in_data;
                wptr_d[k]           = ~wptr_q[k];
            end
            if (pop_k) begin
                rptr_d[k] = ~rptr_q[k];
            end
            cnt_d[k] = cnt_q[k] + {1'b0, push_k} - {1'b0, pop_k};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int k = 0; k < 4; k++) begin
                cnt_q[k]    <= '0;
                mem_q[k][0] <= '0;
                mem_q[k][1] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            mem_q  <= mem_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = {cnt_q[3] != 2'd0, cnt_q[2] != 2'd0,
                            cnt_q[1] != 2'd0, cnt_q[0] != 2'd0};
    assign bus.busy      = |bus.out_valid;

    // Empty ports present zero rather than stale storage.
    assign bus.out_data0 = (cnt_q[0] != 2'd0) ? mem_q[0][rptr_q[0]] : '0;
    assign bus.out_data1 = (cnt_q[1] != 2'd0) ? mem_q[1][rptr_q[1]] : '0;
    assign bus.out_data2 = (cnt_q[2] != 2'd0) ? mem_q[2][rptr_q[2]] : '0;
    assign bus.out_data3 = (cnt_q[3] != 2'd0) ? mem_q[3][rptr_q[3]] : '0;
endmodule

// File: doc/demux4_32_buf.md
DEMUX4_32_BUF -- requirements
Module: demux4_32_buf

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 Parameter DEPTH, fixed at 2, entries per output queue; other values are unsupported.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (reset=0 resets immediately, independent of clk).
REQ-005 in_data  input  WIDTH  word to route.
REQ-006 in_sel  input  2  destination select: 2'b00 to port 0, 2'b01 to port 1, 2'b10 to port 2, 2'b11 to port 3.
REQ-007 in_valid  input  1  in_data/in_sel valid.
REQ-008 in_ready  output  1  block accepts the word this cycle.
REQ-009 out_data0..out_data3  output  WIDTH each  head word of each port queue.
REQ-010 out_valid  output  4  bit k set when port k queue is non-empty.
REQ-011 out_ready  input  4  bit k set when port k consumer takes out_data k this cycle.
REQ-012 busy  output  1  set when any port queue is non-empty.

Function
REQ-013 A word is accepted on a rising edge when in_valid=1 and in_ready=1; it is pushed into the queue selected by in_sel.
REQ-014 in_ready SHALL equal NOT full[in_sel] and has no combinational dependence on out_ready.
REQ-015 A full queue holds exactly DEPTH=2 entries.
REQ-016 A port pops its head on a rising edge when out_valid[k]=1 and out_ready[k]=1.
REQ-017 out_valid[k] SHALL equal NOT empty[k], registered state only.
REQ-018 out_data k SHALL show the head entry when non-empty; it SHALL be all-zero when empty.
REQ-019 Latency: a word accepted at edge N into an empty queue appears on out_data k with out_valid[k]=1 in the cycle after edge N.
REQ-020 Order within a port SHALL be preserved (FIFO). No ordering is defined between ports.
REQ-021 Simultaneous push and pop on the same non-full queue SHALL leave occupancy unchanged and preserve order.
REQ-022 A full queue SHALL deassert in_ready for in_sel selecting it even if out_ready[k]=1 that cycle; the push is taken on a later cycle.
REQ-023 in_sel and in_data may change while in_valid=1 and in_ready=0; in_ready is re-evaluated against the new in_sel each cycle.
REQ-024 Pops on different ports in the same cycle are independent; up to four pops plus one push per cycle.
REQ-025 Read/write pointers are 1 bit per port and wrap modulo 2; occupancy per port is 2 bits (0..2), never exceeding 2 or going below 0.
REQ-026 out_ready[k]=1 with out_valid[k]=0 SHALL have no effect.
REQ-027 in_valid=0 SHALL leave all queues unchanged except for pops.
REQ-028 busy SHALL be the OR of out_valid.

Reset
REQ-029 On reset=0, all queues are emptied asynchronously: out_valid=4'b0000, out_data0..3=0, busy=0, and pointers and counts are 0.
REQ-030 While reset=0, in_ready=0 and no push or pop occurs.
REQ-031 Reset asserted mid-operation discards all buffered words; no partial word appears after release.
REQ-032 The first push is possible on the first rising edge with reset=1.

Verification
REQ-033 Push 32'hA5A5_0001 with in_sel=2'b10 and out_ready=0 -> next cycle out_valid=4'b0100, out_data2=32'hA5A5_0001, busy=1, other out_data=0.
REQ-034 Push 32'h11, 32'h22, 32'h33 to port 1 with out_ready[1]=0 -> first two are accepted; in_ready=0 on the third. Set out_ready[1]=1 -> port 1 emits 11, 22, then 33 is accepted and emitted last.
REQ-035 Port 0 holding 1 entry; push 32'hBEEF to port 0 while popping the same cycle -> occupancy stays 1 and out_data0=32'hBEEF next cycle.
REQ-036 Fill port 3 (2 entries) with in_valid=1 and in_sel=3 -> in_ready=0. Switch in_sel=0 the same cycle -> in_ready=1 and the word lands in port 0.
REQ-037 Fill all four ports, then drive reset=0 between clock edges -> out_valid=0, out_data=0, and busy=0 immediately. After release, push 32'h7 to port 2 -> only 32'h7 appears.
REQ-038 Random in_sel, in_valid, and out_ready for 10k cycles -> scoreboard shows per-port order preserved, no loss or duplication, and in_ready matches NOT full[in_sel] every cycle.
